// File: rtl/class_vec_search.sv
// class_vec_search: nearest-class search over binary hypervectors.
// A query of NUM_FRAMES frames is loaded over a valid/ready stream, then every
// class hypervector is fetched frame by frame from an external generator and
// compared by Hamming distance. The lowest distance wins, and ties keep the
// lower class index.
// Optional feature: define CLASS_VEC_SEARCH_MARGIN_EN to add result_margin
// (second-best distance minus best distance).
module class_vec_search #(
  parameter int NUM_CLASSES = 8,
  parameter int NUM_FRAMES  = 3,
  parameter int FRAME_W     = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [FRAME_W-1:0] q_data,
  output logic [2:0]         frame_id,
  output logic [1:0]         frame_index,
  input  logic [FRAME_W-1:0] class_vec_in,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2:0]         result_class,
  output logic [7:0]         result_dist,
  output logic               busy
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
  ,
  output logic [7:0]         result_margin
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] LAST_FRAME = 2'(NUM_FRAMES - 1);
  localparam logic [2:0] LAST_CLASS = 3'(NUM_CLASSES - 1);

  // Number of set bits in one frame (0..64 fits in 7 bits).
  function automatic logic [6:0] popcount(input logic [FRAME_W-1:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < FRAME_W; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  state_t             state_q;
  logic [1:0]         beat_q;
  // Buffer is sized to the full 2-bit frame address so any index stays in range.
  logic [FRAME_W-1:0] q_buf_q [4];
  logic [2:0]         frame_id_q;
  logic [1:0]         frame_index_q;
  logic [7:0]         acc_q;
  logic [2:0]         best_class_q;
  logic [7:0]         best_dist_q;
  logic               q_ready_q;
  logic               busy_q;
  logic               result_valid_q;
  logic [2:0]         result_class_q;
  logic [7:0]         result_dist_q;
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
  logic [7:0]         second_dist_q;
  logic [7:0]         result_margin_q;
`endif

  logic [6:0] pc_s;
  logic [7:0] acc_base_s;
  logic [7:0] sum_s;
  logic       take_s;

  // Per-cycle distance contribution and the "new best" decision for the current class.
  always_comb begin
    pc_s = popcount(q_buf_q[frame_index_q] ^ class_vec_in);
    if (frame_index_q == 2'd0) begin
      acc_base_s = 8'd0;
    end else begin
      acc_base_s = acc_q;
    end
    sum_s = acc_base_s + {1'b0, pc_s};
    if (frame_id_q == 3'd0) begin
      take_s = 1'b1;
    end else begin
      take_s = (sum_s < best_dist_q);
    end
  end

  // Main FSM: load query, sweep classes, hold result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_q         <= 2'd0;
      frame_id_q     <= 3'd0;
      frame_index_q  <= 2'd0;
      acc_q          <= 8'd0;
      best_class_q   <= 3'd0;
      best_dist_q    <= 8'd0;
      q_ready_q      <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= 3'd0;
      result_dist_q  <= 8'd0;
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
      second_dist_q   <= 8'd0;
      result_margin_q <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (q_valid) begin
            q_buf_q[beat_q] <= q_data;
            if (beat_q == LAST_FRAME) begin
              beat_q        <= 2'd0;
              state_q       <= SEARCH;
              q_ready_q     <= 1'b0;
              busy_q        <= 1'b1;
              frame_id_q    <= 3'd0;
              frame_index_q <= 2'd0;
            end else begin
              beat_q  <= beat_q + 2'd1;
              state_q <= LOAD;
            end
          end
        end
        SEARCH: begin
          acc_q <= sum_s;
          if (frame_index_q == LAST_FRAME) begin
            frame_index_q <= 2'd0;
            if (take_s) begin
              best_class_q <= frame_id_q;
              best_dist_q  <= sum_s;
            end
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
            if (frame_id_q == 3'd0) begin
              second_dist_q <= 8'hFF;
            end else if (take_s) begin
              second_dist_q <= best_dist_q;
            end else if (sum_s < second_dist_q) begin
              second_dist_q <= sum_s;
            end
`endif
            if (frame_id_q == LAST_CLASS) begin
              frame_id_q <= 3'd0;
              state_q    <= DONE;
              busy_q     <= 1'b0;
            end else begin
              frame_id_q <= frame_id_q + 3'd1;
            end
          end else begin
            frame_index_q <= frame_index_q + 2'd1;
          end
        end
        DONE: begin
          if (!result_valid_q) begin
            result_valid_q <= 1'b1;
            result_class_q <= best_class_q;
            result_dist_q  <= best_dist_q;
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
            result_margin_q <= second_dist_q - best_dist_q;
`endif
          end else if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
            q_ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign q_ready      = q_ready_q;
  assign busy         = busy_q;
  assign frame_id     = frame_id_q;
  assign frame_index  = frame_index_q;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_dist  = result_dist_q;
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
  assign result_margin = result_margin_q;
`endif

endmodule

// File: tb/tb_class_vec_search.sv
// Directed self-checking bench for class_vec_search with a behavioural class ROM.
module tb_class_vec_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic        q_ready;
  logic [63:0] q_data;
  logic [2:0]  frame_id;
  logic [1:0]  frame_index;
  logic [63:0] class_vec_in;
  logic        result_valid;
  logic        result_ready;
  logic [2:0]  result_class;
  logic [7:0]  result_dist;
  logic        busy;
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
  logic [7:0]  result_margin;
`endif
  logic        dup_mode;

  int total = 0;
  int bad   = 0;

  class_vec_search dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
    .frame_id(frame_id), .frame_index(frame_index), .class_vec_in(class_vec_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_dist(result_dist), .busy(busy)
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
    , .result_margin(result_margin)
`endif
  );

  always #5 clk = ~clk;

  // Class ROM: spread frames via golden-ratio multiply; dup mode aliases class 6 to class 2.
  function automatic logic [63:0] rom(input logic [2:0] id, input logic [1:0] idx, input logic dup);
    logic [2:0]  e;
    logic [63:0] n;
    e = (dup && id == 3'd6) ? 3'd2 : id;
    n = 64'(e) * 64'd3 + 64'(idx) + 64'd1;
    return (64'h9E37_79B9_7F4A_7C15 * n) ^ {n[31:0], 32'h5A5A_C3C3};
  endfunction

  assign class_vec_in = rom(frame_id, frame_index, dup_mode);

  task automatic beat(input logic [63:0] f);
    @(negedge clk);
    q_valid = 1'b1;
    q_data  = f;
    @(posedge clk);
    #1;
    q_valid = 1'b0;
  endtask

  task automatic send_class(input logic [2:0] id, input logic [63:0] flip1);
    beat(rom(id, 2'd0, 1'b0));
    beat(rom(id, 2'd1, 1'b0) ^ flip1);
    beat(rom(id, 2'd2, 1'b0));
  endtask

  task automatic wait_result(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (q_ready !== 1'b1) begin bad++; $display("FAIL reset_q_ready got=%0b exp=1", q_ready); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%0b exp=0", result_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if ({frame_id, frame_index} !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", frame_id, frame_index); end
    total++; if ({result_class, result_dist} !== 11'd0) begin bad++; $display("FAIL reset_result got=%0d/%0d exp=0/0", result_class, result_dist); end
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
    total++; if (result_margin !== 8'd0) begin bad++; $display("FAIL reset_margin got=%0d exp=0", result_margin); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exact_match;
    int n;
    result_ready = 1'b1;
    send_class(3'd3, 64'd0);
    total++; if (busy !== 1'b1 || q_ready !== 1'b0) begin bad++; $display("FAIL exact_enter_search busy=%0b q_ready=%0b exp=1/0", busy, q_ready); end
    wait_result(n);
    total++; if (n != 25) begin bad++; $display("FAIL exact_latency got=%0d exp=25", n); end
    total++; if (result_class !== 3'd3 || result_dist !== 8'd0) begin bad++; $display("FAIL exact_result got=%0d/%0d exp=3/0", result_class, result_dist); end
    @(posedge clk);
    #1;
    total++; if (result_valid !== 1'b0 || q_ready !== 1'b1) begin bad++; $display("FAIL exact_to_idle rv=%0b q_ready=%0b exp=0/1", result_valid, q_ready); end
  endtask

  task automatic test_one_bit;
    int n;
    send_class(3'd5, 64'd1);
    wait_result(n);
    total++; if (n != 25 || result_class !== 3'd5 || result_dist !== 8'd1) begin bad++; $display("FAIL one_bit got=%0d/%0d lat=%0d exp=5/1 lat=25", result_class, result_dist, n); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_tie;
    int n;
    dup_mode = 1'b1;
    send_class(3'd2, 64'd0);
    wait_result(n);
    total++; if (n != 25 || result_class !== 3'd2 || result_dist !== 8'd0) begin bad++; $display("FAIL tie got=%0d/%0d lat=%0d exp=2/0 lat=25", result_class, result_dist, n); end
`ifdef CLASS_VEC_SEARCH_MARGIN_EN
    total++; if (result_margin !== 8'd0) begin bad++; $display("FAIL tie_margin got=%0d exp=0", result_margin); end
`endif
    @(posedge clk);
    #1;
    dup_mode = 1'b0;
  endtask

  task automatic test_hold;
    int n;
    result_ready = 1'b0;
    send_class(3'd7, 64'd0);
    wait_result(n);
    total++; if (n != 25) begin bad++; $display("FAIL hold_latency got=%0d exp=25", n); end
    @(negedge clk);
    q_valid = 1'b1;
    q_data  = rom(3'd0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (result_valid !== 1'b1 || result_class !== 3'd7 || result_dist !== 8'd0 || q_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d rv=%0b cls=%0d dist=%0d q_ready=%0b exp=1/7/0/0", i, result_valid, result_class, result_dist, q_ready);
      end
    end
    @(negedge clk);
    q_valid      = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (result_valid !== 1'b0 || q_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL hold_release rv=%0b q_ready=%0b busy=%0b exp=0/1/0", result_valid, q_ready, busy); end
    // A full new query only gives the right answer if no stray beat was consumed.
    send_class(3'd1, 64'd0);
    wait_result(n);
    total++; if (n != 25 || result_class !== 3'd1 || result_dist !== 8'd0) begin bad++; $display("FAIL hold_next_query got=%0d/%0d lat=%0d exp=1/0 lat=25", result_class, result_dist, n); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_search;
    int n;
    send_class(3'd4, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    total++; if (frame_id !== 3'd3 || frame_index !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL search_addr got=%0d/%0d busy=%0b exp=3/0/1", frame_id, frame_index, busy); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (q_ready !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0 || frame_id !== 3'd0 ||
        frame_index !== 2'd0 || result_class !== 3'd0 || result_dist !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset q_ready=%0b rv=%0b busy=%0b addr=%0d/%0d res=%0d/%0d", q_ready, result_valid, busy, frame_id, frame_index, result_class, result_dist);
    end
    @(negedge clk);
    rst = 1'b0;
    send_class(3'd6, 64'd0);
    wait_result(n);
    total++; if (n != 25 || result_class !== 3'd6 || result_dist !== 8'd0) begin bad++; $display("FAIL after_reset got=%0d/%0d lat=%0d exp=6/0 lat=25", result_class, result_dist, n); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gaps;
    int n;
    beat(rom(3'd0, 2'd0, 1'b0));
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || q_ready !== 1'b1) begin bad++; $display("FAIL gap_load busy=%0b q_ready=%0b exp=0/1", busy, q_ready); end
    beat(rom(3'd0, 2'd1, 1'b0) ^ 64'h8000_0000_0000_0001);
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_load2 busy=%0b exp=0", busy); end
    beat(rom(3'd0, 2'd2, 1'b0));
    total++; if (busy !== 1'b1 || frame_id !== 3'd0 || frame_index !== 2'd0) begin bad++; $display("FAIL gap_search_start busy=%0b addr=%0d/%0d exp=1/0/0", busy, frame_id, frame_index); end
    wait_result(n);
    total++; if (n != 25 || result_class !== 3'd0 || result_dist !== 8'd2) begin bad++; $display("FAIL gap_result got=%0d/%0d lat=%0d exp=0/2 lat=25", result_class, result_dist, n); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    q_valid      = 1'b0;
    q_data       = 64'd0;
    result_ready = 1'b1;
    dup_mode     = 1'b0;
    test_reset;
    test_exact_match;
    test_one_bit;
    test_tie;
    test_hold;
    test_reset_mid_search;
    test_gaps;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
